// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the core and the ext port.
package dm_arb_pkg;

    localparam int DM_AW = 5;
    localparam int DM_DW = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Core, ext and DM-side signals of the arbiter; slave is the arbiter's view, master the surroundings'.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int AW = DM_AW
);
    logic             core_req;
    logic             core_we;
    logic [AW-1:0]    core_addr;
    logic [DM_DW-1:0] core_wdata;
    logic [DM_DW-1:0] core_rdata;
    logic             core_stall;
    logic             ext_req;
    logic             ext_we;
    logic [AW-1:0]    ext_addr;
    logic [DM_DW-1:0] ext_wdata;
    logic             ext_gnt;
    logic [DM_DW-1:0] ext_rdata;
    logic             ext_rvalid;
    logic [AW-1:0]    dm_addr;
    logic [DM_DW-1:0] dm_wd;
    logic             dm_we;
    logic [DM_DW-1:0] dm_rd;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  dm_rd,
        output core_rdata, core_stall, ext_gnt, ext_rdata, ext_rvalid,
        output dm_addr, dm_wd, dm_we
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output dm_rd,
        input  core_rdata, core_stall, ext_gnt, ext_rdata, ext_rvalid,
        input  dm_addr, dm_wd, dm_we
    );

endinterface

// File: rtl/dm_arb_starve_timer.sv
// Counts consecutive blocked ext cycles and flags the cycle that must trigger a forced grant.
module dm_arb_starve_timer #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic blocked,
    input  logic granted,
    output logic expire
);
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] wait_cnt_r;

    assign expire = blocked & (wait_cnt_r == LAST);

    // Wait counter: restarts on grant, on an idle ext port, and once the force is triggered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (granted || !blocked || expire) begin
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1'b1);
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port DM arbiter: core has priority, ext port takes idle slots, starvation forces a core stall.
// Optional feature: define DM_ARB_PERF_EN to add saturating grant/stall performance counters.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = DM_AW
) (
    input  logic             clk,
    input  logic             reset,
    dm_arbiter_if.slave      bus
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0]      perf_ext_gnt,
    output logic [31:0]      perf_stall
`endif
);
    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    owner_e           owner_s;
    logic             ext_gnt_s;
    logic             core_stall_s;
    logic             blocked_s;
    logic             expire_s;
    logic [AW-1:0]    dm_addr_s;
    logic [DM_DW-1:0] dm_wd_s;
    logic             dm_we_s;
    logic [DM_DW-1:0] ext_rdata_r;
    logic             ext_rvalid_r;

    assign blocked_s = bus.ext_req & ~ext_gnt_s;

    dm_arb_starve_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .blocked (blocked_s),
        .granted (ext_gnt_s),
        .expire  (expire_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: a forced slot lasts exactly one cycle.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE:    state_nxt_s = expire_s ? FORCE : IDLE;
            FORCE:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant/stall decode; both are held low while reset is asserted, even mid-FORCE.
    always_comb begin
        ext_gnt_s    = 1'b0;
        core_stall_s = 1'b0;
        if (!reset) begin
            ext_gnt_s    = 1'b0;
            core_stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ext_gnt_s = bus.ext_req & ~bus.core_req;
                end
                FORCE: begin
                    ext_gnt_s    = bus.ext_req;
                    core_stall_s = bus.core_req & bus.ext_req;
                end
                default: begin
                    ext_gnt_s    = 1'b0;
                    core_stall_s = 1'b0;
                end
            endcase
        end
        owner_s = ext_gnt_s ? OWN_EXT : OWN_CORE;
    end

    // DM port mux: exactly one owner per cycle, so core and ext writes never collide.
    always_comb begin
        dm_addr_s = bus.core_addr;
        dm_wd_s   = bus.core_wdata;
        dm_we_s   = 1'b0;
        case (owner_s)
            OWN_EXT: begin
                dm_addr_s = bus.ext_addr;
                dm_wd_s   = bus.ext_wdata;
                dm_we_s   = bus.ext_we & bus.ext_req;
            end
            default: begin
                dm_addr_s = bus.core_addr;
                dm_wd_s   = bus.core_wdata;
                dm_we_s   = bus.core_we & bus.core_req & reset;
            end
        endcase
    end

    // Ext read-data capture at the end of a granted read cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_rdata_r  <= 32'h0000_0000;
            ext_rvalid_r <= 1'b0;
        end else if (ext_gnt_s && !bus.ext_we) begin
            ext_rdata_r  <= bus.dm_rd;
            ext_rvalid_r <= 1'b1;
        end else begin
            ext_rvalid_r <= 1'b0;
        end
    end

    assign bus.core_rdata = bus.dm_rd;
    assign bus.core_stall = core_stall_s;
    assign bus.ext_gnt    = ext_gnt_s;
    assign bus.ext_rdata  = ext_rdata_r;
    assign bus.ext_rvalid = ext_rvalid_r;
    assign bus.dm_addr    = dm_addr_s;
    assign bus.dm_wd      = dm_wd_s;
    assign bus.dm_we      = dm_we_s;

`ifdef DM_ARB_PERF_EN
    logic [31:0] perf_ext_gnt_r;
    logic [31:0] perf_stall_r;

    // Saturating counters of granted ext accesses and stalled core cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_ext_gnt_r <= 32'd0;
            perf_stall_r   <= 32'd0;
        end else begin
            perf_ext_gnt_r <= ext_gnt_s    ? sat_inc32(perf_ext_gnt_r) : perf_ext_gnt_r;
            perf_stall_r   <= core_stall_s ? sat_inc32(perf_stall_r)   : perf_stall_r;
        end
    end

    assign perf_ext_gnt = perf_ext_gnt_r;
    assign perf_stall   = perf_stall_r;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table, reset corner sequences, random run vs model.
module tb_dm_arbiter;
    localparam int MAX_WAIT = 4;
    localparam int N_RAND   = 2000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(5)) bus ();

`ifdef DM_ARB_PERF_EN
    logic [31:0] perf_ext_gnt;
    logic [31:0] perf_stall;
`endif

    dm_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DM_ARB_PERF_EN
        ,
        .perf_ext_gnt (perf_ext_gnt),
        .perf_stall   (perf_stall)
`endif
    );

    logic [31:0] dm_mem [32] = '{default: 32'h0000_0000};
    assign bus.dm_rd = dm_mem[bus.dm_addr];
    always @(posedge clk) begin
        if (bus.dm_we) dm_mem[bus.dm_addr] <= bus.dm_wd;
    end

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [4:0]  caddr;
        logic [31:0] cwd;
        logic        ereq;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [31:0] ewd;
        logic        gnt;
        logic        stall;
        logic        we;
        logic [4:0]  addr;
        logic        rvalid;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic creq, input logic cwe, input logic [4:0] caddr,
                                input logic [31:0] cwd, input logic ereq, input logic ewe,
                                input logic [4:0] eaddr, input logic [31:0] ewd,
                                input logic gnt, input logic stall, input logic we,
                                input logic [4:0] addr, input logic rvalid, input logic [31:0] rdata);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.ereq = ereq; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
        v.gnt = gnt; v.stall = stall; v.we = we; v.addr = addr;
        v.rvalid = rvalid; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.core_req   = v.creq;
        bus.core_we    = v.cwe;
        bus.core_addr  = v.caddr;
        bus.core_wdata = v.cwd;
        bus.ext_req    = v.ereq;
        bus.ext_we     = v.ewe;
        bus.ext_addr   = v.eaddr;
        bus.ext_wdata  = v.ewd;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk);
        #1 drive(v);
        @(negedge clk);
        chk({tag, " ext_gnt"},    {31'd0, bus.ext_gnt},    {31'd0, v.gnt});
        chk({tag, " core_stall"}, {31'd0, bus.core_stall}, {31'd0, v.stall});
        chk({tag, " dm_we"},      {31'd0, bus.dm_we},      {31'd0, v.we});
        chk({tag, " dm_addr"},    {27'd0, bus.dm_addr},    {27'd0, v.addr});
        if (v.we) chk({tag, " dm_wd"}, bus.dm_wd, v.gnt ? v.ewd : v.cwd);
        chk({tag, " ext_rvalid"}, {31'd0, bus.ext_rvalid}, {31'd0, v.rvalid});
        if (v.rvalid) chk({tag, " ext_rdata"}, bus.ext_rdata, v.rdata);
    endtask

    // Reference model state for the random phase.
    int          blocked_cycles;
    logic [31:0] model_mem [32];
    logic        m_rvalid;
    logic [31:0] m_rdata;
    int          m_gnt_cnt;
    int          m_stall_cnt;

    initial begin
        vec_t v;
        logic [31:0] perf_g0, perf_s0;
        // Test 1: core store held during reset must not reach DM.
        reset = 1'b0;
        drive(mk(1'b1, 1'b1, 5'd3, 32'h1111_0003, 1'b1, 1'b1, 5'd5, 32'h5555_0005,
                 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0));
        repeat (3) @(negedge clk);
        chk("rst dm_we",      {31'd0, bus.dm_we},      32'd0);
        chk("rst ext_gnt",    {31'd0, bus.ext_gnt},    32'd0);
        chk("rst ext_rvalid", {31'd0, bus.ext_rvalid}, 32'd0);
        chk("rst core_stall", {31'd0, bus.core_stall}, 32'd0);
        chk("rst ext_rdata",  bus.ext_rdata,           32'd0);
        chk("rst dm3 untouched", dm_mem[3],            32'd0);
        bus.ext_req = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 chk("release core store dm3", dm_mem[3], 32'h1111_0003);
        bus.core_req = 1'b0;

        // Directed table (MAX_WAIT = 4).
        tbl[0]  = mk(1'b0,1'b0,5'd0,32'h0,        1'b1,1'b1,5'd7, 32'hDEAD_BEEF, 1'b1,1'b0,1'b1,5'd7, 1'b0,32'h0);
        tbl[1]  = mk(1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,5'd7, 32'h0,         1'b1,1'b0,1'b0,5'd7, 1'b0,32'h0);
        tbl[2]  = mk(1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0,1'b0,5'd0, 1'b1,32'hDEAD_BEEF);
        tbl[3]  = mk(1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0,1'b0,5'd0, 1'b0,32'h0);
        for (int i = 4; i < 8; i++)
            tbl[i] = mk(1'b1,1'b1,5'd9,32'h99,    1'b1,1'b1,5'd10,32'hAAAA,      1'b0,1'b0,1'b1,5'd9, 1'b0,32'h0);
        tbl[8]  = mk(1'b1,1'b1,5'd9,32'h99,       1'b1,1'b1,5'd10,32'hAAAA,      1'b1,1'b1,1'b1,5'd10,1'b0,32'h0);
        tbl[9]  = mk(1'b1,1'b1,5'd9,32'h99,       1'b1,1'b1,5'd10,32'hAAAA,      1'b0,1'b0,1'b1,5'd9, 1'b0,32'h0);
        tbl[10] = mk(1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0,1'b0,5'd0, 1'b0,32'h0);
        for (int i = 11; i < 15; i++)
            tbl[i] = mk(1'b1,1'b0,5'd2,32'h0,     1'b1,1'b1,5'd12,32'h5555,      1'b0,1'b0,1'b0,5'd2, 1'b0,32'h0);
        tbl[15] = mk(1'b1,1'b0,5'd2,32'h0,        1'b0,1'b1,5'd12,32'h5555,      1'b0,1'b0,1'b0,5'd2, 1'b0,32'h0);
        tbl[16] = mk(1'b1,1'b0,5'd2,32'h0,        1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0,1'b0,5'd2, 1'b0,32'h0);
        for (int i = 17; i < 21; i++)
            tbl[i] = mk(1'b1,1'b0,5'd2,32'h0,     1'b1,1'b1,5'd12,32'h5555,      1'b0,1'b0,1'b0,5'd2, 1'b0,32'h0);
        tbl[21] = mk(1'b1,1'b0,5'd2,32'h0,        1'b1,1'b1,5'd12,32'h5555,      1'b1,1'b1,1'b1,5'd12,1'b0,32'h0);
        tbl[22] = mk(1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0,1'b0,5'd0, 1'b0,32'h0);
        for (int i = 0; i < 23; i++) run_vec(tbl[i], $sformatf("v%0d", i));
        chk("dm7 ext write",   dm_mem[7],  32'hDEAD_BEEF);
        chk("dm9 core write",  dm_mem[9],  32'h0000_0099);
        chk("dm10 force write", dm_mem[10], 32'h0000_AAAA);
        chk("dm12 force write", dm_mem[12], 32'h0000_5555);

        // Test 6: reset asserted in the middle of a FORCE cycle.
        v = mk(1'b1,1'b0,5'd2,32'h0, 1'b1,1'b1,5'd20,32'h7777, 1'b0,1'b0,1'b0,5'd2, 1'b0,32'h0);
        for (int i = 0; i < 4; i++) run_vec(v, $sformatf("mf pre%0d", i));
        v.gnt = 1'b1; v.stall = 1'b1; v.we = 1'b1; v.addr = 5'd20;
        run_vec(v, "mf force");
        #1 reset = 1'b0;
        #1;
        chk("mf core_stall", {31'd0, bus.core_stall}, 32'd0);
        chk("mf ext_gnt",    {31'd0, bus.ext_gnt},    32'd0);
        chk("mf dm_we",      {31'd0, bus.dm_we},      32'd0);
        bus.ext_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mf dm20 unchanged", dm_mem[20], 32'd0);
        chk("mf ext_rvalid",     {31'd0, bus.ext_rvalid}, 32'd0);
        reset = 1'b1;
        v = mk(1'b1,1'b0,5'd2,32'h0, 1'b1,1'b1,5'd20,32'h7777, 1'b0,1'b0,1'b0,5'd2, 1'b0,32'h0);
        for (int i = 0; i < 4; i++) run_vec(v, $sformatf("mf post%0d", i));
        v.gnt = 1'b1; v.stall = 1'b1; v.we = 1'b1; v.addr = 5'd20;
        run_vec(v, "mf post force");

        // Random phase against the reference model.
        v = mk(1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,5'd0, 1'b0,32'h0);
        run_vec(v, "sync");
        for (int a = 0; a < 32; a++) model_mem[a] = dm_mem[a];
        blocked_cycles = 0;
        m_rvalid = 1'b0;
        m_rdata = 32'h0;
        m_gnt_cnt = 0;
        m_stall_cnt = 0;
`ifdef DM_ARB_PERF_EN
        perf_g0 = perf_ext_gnt;
        perf_s0 = perf_stall;
`else
        perf_g0 = 32'd0;
        perf_s0 = 32'd0;
`endif
        for (int n = 0; n < N_RAND; n++) begin
            logic forced, e_gnt, e_stall, e_we;
            logic [4:0]  e_addr;
            logic [31:0] e_wd;
            @(posedge clk);
            #1;
            bus.core_req   = ($urandom_range(0, 4) != 0);
            bus.core_we    = $urandom_range(0, 1) == 1;
            bus.core_addr  = 5'($urandom_range(0, 31));
            bus.core_wdata = $urandom;
            bus.ext_req    = bus.ext_req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            bus.ext_we     = $urandom_range(0, 1) == 1;
            bus.ext_addr   = 5'($urandom_range(0, 31));
            bus.ext_wdata  = $urandom;
            @(negedge clk);
            // An ext request blocked for MAX_WAIT cycles in a row owns the next cycle outright.
            forced  = (blocked_cycles == MAX_WAIT);
            e_gnt   = bus.ext_req & (forced | ~bus.core_req);
            e_stall = forced & bus.core_req & bus.ext_req;
            e_addr  = e_gnt ? bus.ext_addr  : bus.core_addr;
            e_wd    = e_gnt ? bus.ext_wdata : bus.core_wdata;
            e_we    = e_gnt ? bus.ext_we    : (bus.core_req & bus.core_we);
            chk($sformatf("r%0d ext_gnt", n),    {31'd0, bus.ext_gnt},    {31'd0, e_gnt});
            chk($sformatf("r%0d core_stall", n), {31'd0, bus.core_stall}, {31'd0, e_stall});
            chk($sformatf("r%0d dm_we", n),      {31'd0, bus.dm_we},      {31'd0, e_we});
            chk($sformatf("r%0d dm_addr", n),    {27'd0, bus.dm_addr},    {27'd0, e_addr});
            if (e_we) chk($sformatf("r%0d dm_wd", n), bus.dm_wd, e_wd);
            chk($sformatf("r%0d core_rdata", n), bus.core_rdata, model_mem[e_addr]);
            chk($sformatf("r%0d ext_rvalid", n), {31'd0, bus.ext_rvalid}, {31'd0, m_rvalid});
            if (m_rvalid) chk($sformatf("r%0d ext_rdata", n), bus.ext_rdata, m_rdata);
            m_rvalid = e_gnt & ~bus.ext_we;
            if (m_rvalid) m_rdata = model_mem[bus.ext_addr];
            if (e_we) model_mem[e_addr] = e_wd;
            blocked_cycles = (bus.ext_req & ~e_gnt) ? blocked_cycles + 1 : 0;
            if (e_gnt) m_gnt_cnt++;
            if (e_stall) m_stall_cnt++;
        end
`ifdef DM_ARB_PERF_EN
        @(posedge clk);
        #1;
        chk("perf_ext_gnt delta", perf_ext_gnt - perf_g0, 32'(m_gnt_cnt));
        chk("perf_stall delta",   perf_stall - perf_s0,   32'(m_stall_cnt));
`else
        if (perf_g0 != perf_s0) $display("note: perf baseline differs");
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
